pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush controller with imem timeout and perf counters
//
// Purpose: resolves branch flushes, instruction-memory waits and load-use
// hazards for a short in-order pipeline. Control outputs are combinational
// from the current state and inputs; state and counters update on posedge clk.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   idRs1/idRs2  source registers of the instruction in IF/DE
//   exRd         destination register of the instruction in EX
//   exMemRead    instruction in EX is a load
//   branchTaken  EX resolved a taken branch/jump this cycle
//   imemReady    instruction memory has valid data this cycle
//   pcWrite      PC load enable
//   ifdeWrite    IF/DE load enable
//   ifdeFlush    load a NOP into IF/DE
//   idexFlush    load a bubble into ID/EX
//   stallCnt     saturating count of stall cycles
//   flushCnt     saturating count of branch flushes
//   imemTimeout  sticky: imemReady stayed low for TIMEOUT consecutive cycles
//   state        current FSM state (debug)

module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       idRs1,
   input  logic [4:0]       idRs2,
   input  logic [4:0]       exRd,
   input  logic             exMemRead,
   input  logic             branchTaken,
   input  logic             imemReady,
   output logic             pcWrite,
   output logic             ifdeWrite,
   output logic             ifdeFlush,
   output logic             idexFlush,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt,
   output logic             imemTimeout,
   output logic [1:0]       state
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      IMEM_WAIT = 2'd1,
      LU_STALL  = 2'd2,
      ILLEGAL   = 2'd3
   } state_t;

   state_t            cur_state;
   state_t            nxt_state;
   logic              lu;
   logic              stall_inc;
   logic              flush_inc;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;

   assign state = cur_state;

   assign lu = exMemRead && (exRd != 5'd0) && ((exRd == idRs1) || (exRd == idRs2));

   // Consecutive imemReady-low cycles, saturating at TIMEOUT.
   always_comb begin
      wait_nxt = '0;
      if (!imemReady) begin
         wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state   <= RUN;
         stallCnt    <= '0;
         flushCnt    <= '0;
         wait_cnt    <= '0;
         imemTimeout <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         wait_cnt  <= wait_nxt;
         if (wait_nxt == WAIT_MAX) begin
            imemTimeout <= 1'b1;
         end
         if (stall_inc && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
         end
         if (flush_inc && (flushCnt != '1)) begin
            flushCnt <= flushCnt + CNT_W'(1);
         end
      end
   end

   // Priority: branch > imem wait > load-use > normal. A load-use seen in
   // LU_STALL is ignored because the EX stage now holds the inserted bubble.
   always_comb begin
      nxt_state = RUN;
      pcWrite   = 1'b1;
      ifdeWrite = 1'b1;
      ifdeFlush = 1'b0;
      idexFlush = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;

      if (rst) begin
         pcWrite   = 1'b0;
         ifdeWrite = 1'b0;
         ifdeFlush = 1'b1;
         idexFlush = 1'b1;
      end else if (branchTaken) begin
         ifdeFlush = 1'b1;
         idexFlush = 1'b1;
         flush_inc = 1'b1;
         nxt_state = imemReady ? RUN : IMEM_WAIT;
      end else if (!imemReady) begin
         pcWrite   = 1'b0;
         ifdeFlush = 1'b1;
         stall_inc = 1'b1;
         nxt_state = IMEM_WAIT;
      end else if ((cur_state == RUN) && lu) begin
         pcWrite   = 1'b0;
         ifdeWrite = 1'b0;
         idexFlush = 1'b1;
         stall_inc = 1'b1;
         nxt_state = LU_STALL;
      end

      // The unused encoding always recovers to RUN on the next clock.
      if (cur_state == ILLEGAL) begin
         nxt_state = RUN;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl

module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic [4:0]       idRs1;
   logic [4:0]       idRs2;
   logic [4:0]       exRd;
   logic             exMemRead;
   logic             branchTaken;
   logic             imemReady;
   logic             pcWrite;
   logic             ifdeWrite;
   logic             ifdeFlush;
   logic             idexFlush;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;
   logic             imemTimeout;
   logic [1:0]       state;

   int checks;
   int errors;

   pipeline_hazard_ctrl #(.TIMEOUT(16), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .idRs1(idRs1),
      .idRs2(idRs2),
      .exRd(exRd),
      .exMemRead(exMemRead),
      .branchTaken(branchTaken),
      .imemReady(imemReady),
      .pcWrite(pcWrite),
      .ifdeWrite(ifdeWrite),
      .ifdeFlush(ifdeFlush),
      .idexFlush(idexFlush),
      .stallCnt(stallCnt),
      .flushCnt(flushCnt),
      .imemTimeout(imemTimeout),
      .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // {pcWrite, ifdeWrite, ifdeFlush, idexFlush}, sampled mid-cycle
   task automatic check_ctrl(input string tag, input logic [3:0] expected);
      #1;
      check(tag, {28'd0, pcWrite, ifdeWrite, ifdeFlush, idexFlush}, {28'd0, expected});
   endtask

   // advance one clock; inputs may be changed right after return
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      idRs1 = 5'd0; idRs2 = 5'd0; exRd = 5'd0;
      exMemRead = 1'b0; branchTaken = 1'b0; imemReady = 1'b1;
   endtask

   task automatic set_lu();
      exMemRead = 1'b1; exRd = 5'd5; idRs1 = 5'd1; idRs2 = 5'd5;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      idle_inputs();

      // reset
      check_ctrl("rst_outputs", 4'b0011);
      tick();
      tick();
      check("rst_state", {30'd0, state}, 32'd0);
      check("rst_stall", {28'd0, stallCnt}, 32'd0);
      check("rst_flush", {28'd0, flushCnt}, 32'd0);
      check("rst_timeout", {31'd0, imemTimeout}, 32'd0);
      rst = 1'b0;
      check_ctrl("normal_run", 4'b1100);
      tick();

      // load-use: stall one cycle, then LU_STALL with normal outputs
      set_lu();
      check_ctrl("lu_stall_ctrl", 4'b0001);
      tick();
      check("lu_state", {30'd0, state}, 32'd2);
      check_ctrl("lu_stall_ignores_fresh_lu", 4'b1100);
      tick();
      check("lu_back_run", {30'd0, state}, 32'd0);
      check("lu_stallcnt", {28'd0, stallCnt}, 32'd1);

      // load to x0 causes no stall
      idle_inputs();
      exMemRead = 1'b1; exRd = 5'd0; idRs1 = 5'd0;
      check_ctrl("x0_no_stall", 4'b1100);
      tick();
      check("x0_state", {30'd0, state}, 32'd0);
      check("x0_stallcnt", {28'd0, stallCnt}, 32'd1);

      // branch during imem wait
      idle_inputs();
      imemReady = 1'b0;
      check_ctrl("imem_wait_ctrl", 4'b0110);
      tick();
      check("imem_wait_state", {30'd0, state}, 32'd1);
      branchTaken = 1'b1;
      check_ctrl("branch_in_wait_ctrl", 4'b1111);
      tick();
      check("branch_in_wait_state", {30'd0, state}, 32'd1);
      branchTaken = 1'b0;
      tick();
      check("wait3_state", {30'd0, state}, 32'd1);
      check("wait_stallcnt", {28'd0, stallCnt}, 32'd3);
      check("wait_flushcnt", {28'd0, flushCnt}, 32'd1);
      imemReady = 1'b1;
      check_ctrl("wait_release_ctrl", 4'b1100);
      tick();
      check("wait_release_state", {30'd0, state}, 32'd0);

      // branch together with load-use: flush only
      set_lu();
      branchTaken = 1'b1;
      check_ctrl("branch_lu_ctrl", 4'b1111);
      tick();
      check("branch_lu_state", {30'd0, state}, 32'd0);
      check("branch_lu_flushcnt", {28'd0, flushCnt}, 32'd2);
      check("branch_lu_stallcnt", {28'd0, stallCnt}, 32'd3);

      // timeout after 16 consecutive not-ready cycles; stall counter saturates
      idle_inputs();
      imemReady = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("timeout_not_yet", {31'd0, imemTimeout}, 32'd0);
      tick();
      check("timeout_set", {31'd0, imemTimeout}, 32'd1);
      check("stallcnt_sat", {28'd0, stallCnt}, 32'd15);
      imemReady = 1'b1;
      tick();
      check("timeout_sticky", {31'd0, imemTimeout}, 32'd1);
      check("after_timeout_state", {30'd0, state}, 32'd0);
      set_lu();
      check_ctrl("sat_lu_ctrl", 4'b0001);
      tick();
      check("stallcnt_stays_sat", {28'd0, stallCnt}, 32'd15);

      // flush counter saturation
      idle_inputs();
      tick();
      branchTaken = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      check("flushcnt_sat", {28'd0, flushCnt}, 32'd15);
      branchTaken = 1'b0;

      // reset mid load-use stall
      set_lu();
      tick();
      check("pre_rst_lu_state", {30'd0, state}, 32'd2);
      rst = 1'b1;
      check_ctrl("rst_mid_stall_ctrl", 4'b0011);
      tick();
      rst = 1'b0;
      idle_inputs();
      check("rst_mid_stall_state", {30'd0, state}, 32'd0);
      check("rst_clears_timeout", {31'd0, imemTimeout}, 32'd0);
      check("rst_clears_stall", {28'd0, stallCnt}, 32'd0);
      check("rst_clears_flush", {28'd0, flushCnt}, 32'd0);
      check_ctrl("post_rst_normal", 4'b1100);
      tick();
      check("post_rst_run", {30'd0, state}, 32'd0);

      // reset mid imem wait
      imemReady = 1'b0;
      tick();
      check("pre_rst_wait_state", {30'd0, state}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      imemReady = 1'b1;
      check("rst_mid_wait_state", {30'd0, state}, 32'd0);
      check_ctrl("post_rst_wait_normal", 4'b1100);
      tick();
      check("post_rst_wait_run", {30'd0, state}, 32'd0);
      check("post_rst_wait_stallcnt", {28'd0, stallCnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
